// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter for the shared single-port data memory between the CPU
// and the loader/debug port. It also sequences a full-memory clear.
module data_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              addr_err,
    input  logic              clear_start,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RD,
        S_CLEAR
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_rr_last;
    logic                r_clr_pend;
    logic                r_port;
    logic                r_we;
    logic                r_err;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;
    logic                r_rvalid0;
    logic                r_rvalid1;

    logic                w_go_clear;
    logic                w_take;
    logic                w_win;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [DATA_W-1:0]   w_rd_val;

    // Arbitration: a pending clear always wins over requests.
    always_comb begin
        w_go_clear  = (r_state == S_IDLE) && (r_clr_pend || clear_start);
        w_take      = (r_state == S_IDLE) && !w_go_clear && (req0 || req1);
        w_win       = (req0 && req1) ? !r_rr_last : req1;
        w_sel_we    = w_win ? we1 : we0;
        w_sel_addr  = w_win ? addr1 : addr0;
        w_sel_wdata = w_win ? wdata1 : wdata0;
        w_rd_val    = r_err ? '0 : mem_rdata;
    end

    always_comb begin
        w_next    = r_state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        addr_err  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_go_clear) w_next = S_CLEAR;
                else if (w_take) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                gnt0      = !r_port;
                gnt1      = r_port;
                addr_err  = r_err;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
                mem_wr    = r_we && !r_err;
                mem_rd    = !r_we && !r_err;
                w_next    = r_we ? S_IDLE : S_WAIT_RD;
            end
            S_WAIT_RD: begin
                w_next = S_IDLE;
            end
            S_CLEAR: begin
                mem_addr = r_clr_cnt;
                mem_wr   = 1'b1;
                if (r_clr_cnt == ADDR_W'(DEPTH - 1)) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_rr_last  <= 1'b1;
            r_clr_pend <= 1'b0;
            r_port     <= 1'b0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_clr_cnt  <= '0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            if (w_take) begin
                r_port    <= w_win;
                r_rr_last <= w_win;
                r_we      <= w_sel_we;
                r_addr    <= w_sel_addr;
                r_wdata   <= w_sel_wdata;
                r_err     <= (w_sel_addr >= ADDR_W'(DEPTH));
            end
            if (r_state != S_IDLE && clear_start) r_clr_pend <= 1'b1;
            else if (w_go_clear) r_clr_pend <= 1'b0;
            if (w_go_clear) r_clr_cnt <= '0;
            else if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
            // Read result lands one cycle after the memory's registered read.
            if (r_state == S_WAIT_RD) begin
                if (r_port) begin
                    r_rdata1  <= w_rd_val;
                    r_rvalid1 <= 1'b1;
                end else begin
                    r_rdata0  <= w_rd_val;
                    r_rvalid0 <= 1'b1;
                end
            end
        end
    end

    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign busy    = (r_state != S_IDLE);

endmodule
